// File: rtl/name_entry_pkg.sv
// Shared key-code constants and controller state encoding for the name entry buffer.
package name_entry_pkg;

  localparam logic [7:0] KEY_LETTER_MIN = 8'h00;
  localparam logic [7:0] KEY_LETTER_MAX = 8'h19;
  localparam logic [7:0] KEY_DIGIT_MIN  = 8'h34;
  localparam logic [7:0] KEY_DIGIT_MAX  = 8'h3D;
  localparam logic [7:0] KEY_UNKNOWN    = 8'h61;
  localparam logic [7:0] KEY_BKSP       = 8'h62;
  localparam logic [7:0] KEY_ENTER      = 8'h63;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Wrapping subtraction turns an inclusive range test into a single compare.
  function automatic logic key_in_range(input logic [7:0] code,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (code - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/key_classify.sv
// Combinational decode of a key code into printable / backspace / enter / invalid classes.
module key_classify
  import name_entry_pkg::*;
#(
  parameter int ALLOW_DIGITS = 1
) (
  input  logic [7:0] i_key_code,
  output logic       o_printable,
  output logic       o_backspace,
  output logic       o_enter,
  output logic       o_invalid
);

  logic w_letter;
  logic w_digit;

  always_comb begin
    w_letter    = key_in_range(i_key_code, KEY_LETTER_MIN, KEY_LETTER_MAX);
    w_digit     = (ALLOW_DIGITS != 0) && key_in_range(i_key_code, KEY_DIGIT_MIN, KEY_DIGIT_MAX);
    o_printable = w_letter | w_digit;
    o_backspace = (i_key_code == KEY_BKSP);
    o_enter     = (i_key_code == KEY_ENTER);
    o_invalid   = ~(o_printable | o_backspace | o_enter);
  end

endmodule

// File: rtl/name_entry_buffer.sv
// Keyboard-driven name editor: live slot buffer, backspace, and an enter-triggered
// commit snapshot held until the consumer handshakes it away.
module name_entry_buffer
  import name_entry_pkg::*;
#(
  parameter int MAX_LEN      = 10,
  parameter int CHAR_W       = 6,
  parameter int ALLOW_DIGITS = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      key_valid,
  input  logic [7:0]                key_code,
  output logic [MAX_LEN*CHAR_W-1:0] name,
  output logic [4:0]                length,
  output logic                      full,
  output logic                      commit_valid,
  output logic [MAX_LEN*CHAR_W-1:0] commit_name,
  output logic [4:0]                commit_len,
  input  logic                      commit_ready,
  output logic                      char_pulse,
  output logic                      bksp_pulse,
  output logic                      reject_pulse
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CHAR_W-1:0]           r_slot [MAX_LEN];
  logic [4:0]                  r_len;
  logic [MAX_LEN*CHAR_W-1:0]   r_commit_name;
  logic [4:0]                  r_commit_len;
  logic                        r_char_pulse;
  logic                        r_bksp_pulse;
  logic                        r_reject_pulse;

  logic                        w_printable;
  logic                        w_backspace;
  logic                        w_enter;
  logic                        w_invalid;
  logic                        w_full;
  logic                        w_append;
  logic                        w_remove;
  logic                        w_commit;
  logic                        w_reject;
  logic [CHAR_W-1:0]           w_char;
  logic [MAX_LEN*CHAR_W-1:0]   w_name;

  key_classify #(
    .ALLOW_DIGITS (ALLOW_DIGITS)
  ) u_key_classify (
    .i_key_code  (key_code),
    .o_printable (w_printable),
    .o_backspace (w_backspace),
    .o_enter     (w_enter),
    .o_invalid   (w_invalid)
  );

  // Anything not explicitly accepted below (including w_invalid keys) is rejected.
  always_comb begin
    w_full   = (r_len == 5'(MAX_LEN));
    w_char   = CHAR_W'(key_code) + CHAR_W'(1);
    w_append = key_valid & w_printable & ~w_full;
    w_remove = key_valid & w_backspace & (r_len != 5'd0);
    w_commit = key_valid & w_enter & (r_state == ST_EDIT) & (r_len != 5'd0);
    w_reject = key_valid & ~(w_append | w_remove | w_commit);
  end

  always_comb begin
    w_name = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_name[i*CHAR_W +: CHAR_W] = r_slot[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EDIT: if (w_commit)     w_state_nxt = ST_HOLD;
      ST_HOLD: if (commit_ready) w_state_nxt = ST_EDIT;
      default:                   w_state_nxt = ST_EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EDIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_slot[i] <= '0;
      end
      r_len          <= '0;
      r_commit_name  <= '0;
      r_commit_len   <= '0;
      r_char_pulse   <= 1'b0;
      r_bksp_pulse   <= 1'b0;
      r_reject_pulse <= 1'b0;
    end else begin
      if (w_commit) begin
        r_commit_name <= w_name;
        r_commit_len  <= r_len;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          r_slot[i] <= '0;
        end
        r_len <= '0;
      end else if (w_append) begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          if (5'(i) == r_len) r_slot[i] <= w_char;
        end
        r_len <= r_len + 5'd1;
      end else if (w_remove) begin
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
          if (5'(i) == (r_len - 5'd1)) r_slot[i] <= '0;
        end
        r_len <= r_len - 5'd1;
      end
      r_char_pulse   <= w_append;
      r_bksp_pulse   <= w_remove;
      r_reject_pulse <= w_reject;
    end
  end

  always_comb begin
    name         = w_name;
    length       = r_len;
    full         = w_full;
    commit_valid = (r_state == ST_HOLD);
    commit_name  = r_commit_name;
    commit_len   = r_commit_len;
    char_pulse   = r_char_pulse;
    bksp_pulse   = r_bksp_pulse;
    reject_pulse = r_reject_pulse;
  end

endmodule
